// File: rtl/ctrl_pipe.sv
// Pipelined control unit: decodes the ID opcode into the control bundle, carries it
// through ID/EX, EX/MEM and MEM/WB, and resolves stalls, flushes, freezes and forwarding.
module ctrl_pipe #(
  parameter int REG_AW        = 5,
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter int CNT_W         = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [6:0]        id_opcode,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              ex_redirect,
  input  logic              mem_ready,
  output logic              hold_if_id,
  output logic              flush_if_id,
  output logic              id_illegal,
  output logic              ex_alusrc,
  output logic [1:0]        ex_aluop,
  output logic [1:0]        ex_pc_reg,
  output logic              ex_branch,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              mem_read,
  output logic              mem_write,
  output logic              wb_regwrite,
  output logic              wb_memtoreg,
  output logic [REG_AW-1:0] wb_rd,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_IALU  = 7'b0010011;

  typedef struct packed {
    logic              alusrc;
    logic [1:0]        aluop;
    logic [1:0]        pc_reg;
    logic              branch;
    logic              regwrite;
    logic              memtoreg;
    logic              memread;
    logic              memwrite;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
  } ex_ctl_t;

  function automatic logic [1:0] fwd_sel(
    input logic [REG_AW-1:0] rs,
    input logic              m_we,
    input logic [REG_AW-1:0] m_rd,
    input logic              w_we,
    input logic [REG_AW-1:0] w_rd
  );
    if (m_we && m_rd != '0 && m_rd == rs) return 2'b10;
    if (w_we && w_rd != '0 && w_rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  ex_ctl_t           dec;
  ex_ctl_t           ex_q;
  logic              rs1_used, rs2_used, known;
  logic              mem_freeze, load_use;
  logic              ex_regwrite, ex_memtoreg, ex_memread, ex_memwrite;
  logic [REG_AW-1:0] ex_rd, ex_rs1, ex_rs2;
  logic              mem_regwrite, mem_memtoreg;
  logic [REG_AW-1:0] mem_rd;

  // ID stage: opcode decode into the bundle; invalid or unknown opcodes become a bubble
  always_comb begin
    dec      = '0;
    rs1_used = 1'b0;
    rs2_used = 1'b0;
    known    = 1'b1;
    case (id_opcode)
      OP_LUI:   begin dec.alusrc = 1'b1; dec.regwrite = 1'b1; end
      OP_AUIPC: begin dec.regwrite = 1'b1; dec.pc_reg = 2'b01; end
      OP_JAL:   begin dec.regwrite = 1'b1; dec.branch = 1'b1; dec.pc_reg = 2'b10; end
      OP_JALR:  begin dec.regwrite = 1'b1; dec.pc_reg = 2'b11; rs1_used = 1'b1; end
      OP_B:     begin dec.branch = 1'b1; dec.aluop = 2'b01; rs1_used = 1'b1; rs2_used = 1'b1; end
      OP_R:     begin dec.regwrite = 1'b1; dec.aluop = 2'b10; rs1_used = 1'b1; rs2_used = 1'b1; end
      OP_LW: begin
        dec.alusrc = 1'b1; dec.regwrite = 1'b1; dec.memtoreg = 1'b1; dec.memread = 1'b1;
        rs1_used = 1'b1;
      end
      OP_SW:    begin dec.alusrc = 1'b1; dec.memwrite = 1'b1; rs1_used = 1'b1; rs2_used = 1'b1; end
      OP_IALU:  begin dec.alusrc = 1'b1; dec.regwrite = 1'b1; dec.aluop = 2'b11; rs1_used = 1'b1; end
      default:  known = 1'b0;
    endcase
    dec.rd  = id_rd;
    dec.rs1 = id_rs1;
    dec.rs2 = id_rs2;
    if (!id_valid || !known) begin
      dec      = '0;
      rs1_used = 1'b0;
      rs2_used = 1'b0;
    end
  end

  assign id_illegal = id_valid && !known;

  assign ex_alusrc   = ex_q.alusrc;
  assign ex_aluop    = ex_q.aluop;
  assign ex_pc_reg   = ex_q.pc_reg;
  assign ex_branch   = ex_q.branch;
  assign ex_regwrite = ex_q.regwrite;
  assign ex_memtoreg = ex_q.memtoreg;
  assign ex_memread  = ex_q.memread;
  assign ex_memwrite = ex_q.memwrite;
  assign ex_rd       = ex_q.rd;
  assign ex_rs1      = ex_q.rs1;
  assign ex_rs2      = ex_q.rs2;

  assign mem_freeze = MEM_HANDSHAKE && (mem_read || mem_write) && !mem_ready;
  assign load_use   = ex_memread && ex_rd != '0 &&
                      ((rs1_used && ex_rd == id_rs1) || (rs2_used && ex_rd == id_rs2));

  // A freeze outranks a redirect, which in turn outranks a load-use stall
  assign hold_if_id  = !reset && (mem_freeze || (!ex_redirect && load_use));
  assign flush_if_id = !reset && !mem_freeze && ex_redirect;

  assign fwd_a = fwd_sel(ex_rs1, mem_regwrite, mem_rd, wb_regwrite, wb_rd);
  assign fwd_b = fwd_sel(ex_rs2, mem_regwrite, mem_rd, wb_regwrite, wb_rd);

  // ID/EX, EX/MEM, MEM/WB registers and stall counter
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q         <= '0;
      mem_read     <= 1'b0;
      mem_write    <= 1'b0;
      mem_regwrite <= 1'b0;
      mem_memtoreg <= 1'b0;
      mem_rd       <= '0;
      wb_regwrite  <= 1'b0;
      wb_memtoreg  <= 1'b0;
      wb_rd        <= '0;
      stall_cnt    <= '0;
    end else begin
      if (mem_freeze) begin
        wb_regwrite <= 1'b0;
        wb_memtoreg <= 1'b0;
        wb_rd       <= '0;
      end else begin
        ex_q         <= (ex_redirect || load_use) ? '0 : dec;
        mem_read     <= ex_memread;
        mem_write    <= ex_memwrite;
        mem_regwrite <= ex_regwrite;
        mem_memtoreg <= ex_memtoreg;
        mem_rd       <= ex_rd;
        wb_regwrite  <= mem_regwrite;
        wb_memtoreg  <= mem_memtoreg;
        wb_rd        <= mem_rd;
      end
      if (hold_if_id && stall_cnt != {CNT_W{1'b1}})
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/ctrl_pipe.md
Name: ctrl_pipe

Overview:
- Pipelined successor to the combinational main decoder.
- Decodes the ID-stage opcode into the standard control bundle and carries it through the ID/EX, EX/MEM and MEM/WB control registers.
- Adds load-use stall, taken-branch/jump flush, data-memory wait-state freeze, EX forwarding selects and a stall-cycle counter.
- Sits beside the datapath pipeline registers and drives their enables and bubble inputs.

Parameters:
- REG_AW, 5, register-address width (rd/rs1/rs2).
- MEM_HANDSHAKE, 1, 1: honour mem_ready; 0: mem_ready ignored, treated as 1.
- CNT_W, 32, width of stall_cnt.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_opcode  in  7  instruction[6:0] in ID.
- id_rs1, id_rs2, id_rd  in  REG_AW  register fields in ID.
- ex_redirect  in  1  EX resolved a taken branch, JAL or JALR this cycle.
- mem_ready  in  1  data memory completes the current MEM access this cycle.
- hold_if_id  out  1  freeze PC and IF/ID.
- flush_if_id  out  1  IF/ID loads a bubble.
- id_illegal  out  1  id_valid with an undecodable opcode (combinational).
- ex_alusrc  out  1  EX control, registered.
- ex_aluop  out  2  EX control, registered.
- ex_pc_reg  out  2  EX control, registered.
- ex_branch  out  1  EX control, registered.
- fwd_a, fwd_b  out  2  ALU operand source: 00 regfile, 01 WB result, 10 MEM result.
- mem_read, mem_write  out  1  MEM-stage controls.
- wb_regwrite, wb_memtoreg  out  1  WB-stage controls.
- wb_rd  out  REG_AW  WB destination.
- stall_cnt  out  CNT_W  count of cycles with hold_if_id=1.

Behaviour:
- Opcode map: LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, B 1100011, R 0110011, LW 0000011, SW 0100011, I-ALU 0010011.
- ALUSrc=LW|SW|I-ALU|LUI.
- MemtoReg=MemRead=LW.
- MemWrite=SW.
- RegWrite=R|LW|I-ALU|LUI|AUIPC|JAL|JALR.
- Branch=B|JAL.
- ALUOp: B→01, R→10, I-ALU→11, else 00.
- PC_Reg: AUIPC→01, JAL→10, JALR→11, else 00.
- Unknown opcode or id_valid=0: bundle all-zero (bubble); id_illegal=1 only for unknown opcode with id_valid.
- Register usage: rs1 used by all opcodes except LUI, AUIPC, JAL. rs2 used by R, SW, B.
- Internal registered fields: ex_rd, ex_rs1, ex_rs2, ex_regwrite, ex_memtoreg, ex_memread, ex_memwrite; mem_rd, mem_regwrite, mem_memtoreg.
- Reset: every registered output and internal field → 0; stall_cnt → 0; no stall or flush asserted in the reset cycle.
- Priority each cycle, highest first:
  1. mem_freeze = MEM_HANDSHAKE && (mem_read|mem_write) && !mem_ready.
     - ID/EX and EX/MEM hold.
     - MEM/WB loads a bubble (wb_regwrite=0).
     - hold_if_id=1, flush_if_id=0.
     - ex_redirect is ignored while freeze holds; the datapath holds it stable.
  2. ex_redirect: flush_if_id=1, ID/EX loads a bubble, EX/MEM advances normally.
  3. load_use = ex_memread && ex_rd!=0 && ((rs1 used && ex_rd==id_rs1) || (rs2 used && ex_rd==id_rs2)).
     - hold_if_id=1, ID/EX loads a bubble, later stages advance.
  4. Otherwise all stages advance.
- Latency: the control bundle reaches EX 1 cycle after ID, MEM after 2, WB after 3, excluding stalls.
- Forwarding, combinational from registered state:
  - fwd_a=10 if mem_regwrite && mem_rd!=0 && mem_rd==ex_rs1;
  - else 01 if wb_regwrite && wb_rd!=0 && wb_rd==ex_rs1;
  - else 00.
  - fwd_b uses the same rule with ex_rs2. MEM beats WB.
- A bubble clears rd, rs1, rs2 and all control bits.
- stall_cnt increments when hold_if_id=1 and saturates at all-ones.
- Reset mid-freeze or mid-stall: next cycle all pipeline control is 0 and hold/flush deassert.

Test Plan:
- Reset with id_valid=1, R-type → after release: ex_aluop=10 one cycle later, wb_regwrite=1 three cycles after ID, stall_cnt=0.
- LW x5 followed by ADD x6,x5,x1 → hold_if_id=1 for exactly 1 cycle, one bubble in EX, then fwd_a=01 for the ADD, stall_cnt=1.
- LW x0 followed by a use of x0 → no stall; ADD x3 then SUB using x3 → fwd_a=10 with no stall.
- ex_redirect=1 coinciding with a load_use condition → flush_if_id=1, hold_if_id=0, ID/EX bubble.
- SW in MEM with mem_ready low for 3 cycles → hold_if_id=1 for 3 cycles, wb_regwrite=0 during freeze, stall_cnt=3; repeat with MEM_HANDSHAKE=0 → no freeze.
- id_opcode=1111111 with id_valid=1 → id_illegal=1, all-zero bundle in EX; reset asserted during a freeze → all outputs 0 next cycle.
